// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake and one-cycle latency.
// Define PIPE_SKID_EN for a registered in_ready backed by a second skid entry.
module pipe_stage_reg #(
    parameter int                 INSTR_W      = 32,
    parameter int                 DATA_W       = 32,
    parameter int                 PC_W         = 14,
    parameter int                 CTRL_W       = 8,
    parameter logic [INSTR_W-1:0] BUBBLE_INSTR = 32'h00000013
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instruction_in,
    input  logic [DATA_W-1:0]  alu_result_in,
    input  logic [PC_W-1:0]    pc_in,
    input  logic [CTRL_W-1:0]  ctrl_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] instruction_out,
    output logic [DATA_W-1:0]  alu_result_out,
    output logic [PC_W-1:0]    pc_out,
    output logic [CTRL_W-1:0]  ctrl_out
);

    localparam int E_W = INSTR_W + DATA_W + PC_W + CTRL_W;

`ifdef PIPE_SKID_EN
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;
`else
    typedef enum logic {
        EMPTY = 1'b0,
        ONE   = 1'b1
    } state_t;
`endif

    state_t         state;
    state_t         state_nx;
    logic [E_W-1:0] head_q;
    logic [E_W-1:0] in_entry;
    logic           rdy_q;
    logic           in_fire;
    logic           out_fire;
    logic           load_head;

    assign in_entry  = {instruction_in, alu_result_in, pc_in, ctrl_in};
    assign out_valid = (state != EMPTY);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign load_head = in_fire && ((state == EMPTY) || out_fire);

`ifdef PIPE_SKID_EN
    logic [E_W-1:0] skid_q;

    assign in_ready = rdy_q;
`else
    // rdy_q gates the combinational ready until the first edge after reset
    assign in_ready = rdy_q && ((state == EMPTY) || out_ready);
`endif

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) state_nx = ONE;
                end
                ONE: begin
`ifdef PIPE_SKID_EN
                    if (in_fire && !out_fire) state_nx = TWO;
                    else
`endif
                    if (!in_fire && out_fire) state_nx = EMPTY;
                end
`ifdef PIPE_SKID_EN
                TWO: begin
                    if (out_fire) state_nx = ONE;
                end
`endif
                default: state_nx = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= EMPTY;
            rdy_q <= 1'b0;
        end else begin
            state <= state_nx;
`ifdef PIPE_SKID_EN
            rdy_q <= (state_nx != TWO);
`else
            rdy_q <= 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q <= '0;
`ifdef PIPE_SKID_EN
            skid_q <= '0;
`endif
        end else if (!flush) begin
            if (load_head) begin
                head_q <= in_entry;
            end
`ifdef PIPE_SKID_EN
            else if ((state == TWO) && out_fire) begin
                head_q <= skid_q;
            end
            if (in_fire && (state == ONE) && !out_fire) begin
                skid_q <= in_entry;
            end
`endif
        end
    end

    assign instruction_out = out_valid ?
        head_q[E_W-1 -: INSTR_W] : BUBBLE_INSTR;
    assign alu_result_out  = out_valid ?
        head_q[PC_W+CTRL_W +: DATA_W] : '0;
    assign pc_out          = out_valid ?
        head_q[CTRL_W +: PC_W] : '0;
    assign ctrl_out        = out_valid ?
        head_q[CTRL_W-1:0] : '0;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed vector bench for pipe_stage_reg (flow, stall, flush, reset).
// Expectations adapt to PIPE_SKID_EN when that macro is defined.
module tb_pipe_stage_reg;

`ifdef PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction_in;
    logic [31:0] alu_result_in;
    logic [13:0] pc_in;
    logic [7:0]  ctrl_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instruction_out;
    logic [31:0] alu_result_out;
    logic [13:0] pc_out;
    logic [7:0]  ctrl_out;

    int n_total = 0;
    int n_pass  = 0;

    pipe_stage_reg dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .instruction_in (instruction_in),
        .alu_result_in  (alu_result_in),
        .pc_in          (pc_in),
        .ctrl_in        (ctrl_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .instruction_out(instruction_out),
        .alu_result_out (alu_result_out),
        .pc_out         (pc_out),
        .ctrl_out       (ctrl_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit        iv;
        bit        ordy;
        bit        fl;
        bit [13:0] pc;
        bit        e_rdy;
        bit        e_ov;
        bit [13:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] f_instr(input logic [13:0] p);
        if (p == 14'h0020) return 32'h00A00093;
        return {p[11:0], 20'h00113};
    endfunction

    function automatic logic [31:0] f_alu(input logic [13:0] p);
        return 32'hDEAD0000 | {18'd0, p};
    endfunction

    function automatic logic [7:0] f_ctrl(input logic [13:0] p);
        return p[9:2] ^ 8'h5A;
    endfunction

    task automatic add(input bit iv, input bit ordy, input bit fl,
                       input bit [13:0] pc, input bit e_rdy,
                       input bit e_ov, input bit [13:0] e_pc);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.fl = fl; v.pc = pc;
        v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_pc = e_pc;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (t=%0t)",
                      name, act, exp, $time);
    endtask

    task automatic drive(input bit iv, input bit ordy, input bit fl,
                         input logic [13:0] pc);
        in_valid       = iv;
        out_ready      = ordy;
        flush          = fl;
        pc_in          = pc;
        instruction_in = f_instr(pc);
        alu_result_in  = f_alu(pc);
        ctrl_in        = f_ctrl(pc);
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, ".out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, ".instr"}, instruction_out, 32'h00000013);
        chk({tag, ".alu"}, alu_result_out, 32'd0);
        chk({tag, ".pc"}, {18'd0, pc_out}, 32'd0);
        chk({tag, ".ctrl"}, {24'd0, ctrl_out}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // flow: three back-to-back entries
        add(1, 1, 0, 14'h004, 1, 1, 14'h004);
        add(1, 1, 0, 14'h008, 1, 1, 14'h008);
        add(1, 1, 0, 14'h00C, 1, 1, 14'h00C);
        add(0, 1, 0, 14'h000, 1, 0, 14'h000);
        // simultaneous in/out for 10 cycles while in ONE
        add(1, 1, 0, 14'h100, 1, 1, 14'h100);
        for (int k = 1; k <= 10; k++)
            add(1, 1, 0, 14'h100 + 14'(4 * k), 1, 1,
                14'h100 + 14'(4 * k));
        add(0, 1, 0, 14'h000, 1, 0, 14'h000);
        // stall with head held
        add(1, 0, 0, 14'h020, 1, 1, 14'h020);
        add(1, 0, 0, 14'h024, SKID, 1, 14'h020);
        add(1, 0, 0, 14'h024, 0, 1, 14'h020);
        add(0, 1, 0, 14'h000, !SKID, SKID, 14'h024);
        add(0, 1, 0, 14'h000, 1, 0, 14'h000);
        // flush while holding entries and offered entry
        add(1, 0, 0, 14'h030, 1, 1, 14'h030);
        add(1, 0, 0, 14'h034, SKID, 1, 14'h030);
        add(1, 0, 1, 14'h03C, 0, 0, 14'h000);
        add(0, 1, 0, 14'h000, 1, 0, 14'h000);
        add(0, 1, 0, 14'h000, 1, 0, 14'h000);
        // flush coinciding with a consume: no replay
        add(1, 1, 0, 14'h040, 1, 1, 14'h040);
        add(1, 1, 1, 14'h044, 1, 0, 14'h000);
        add(0, 1, 0, 14'h000, 1, 0, 14'h000);
        add(1, 1, 0, 14'h048, 1, 1, 14'h048);
        add(0, 1, 0, 14'h000, 1, 0, 14'h000);

        rst = 1'b0;
        drive(0, 1, 0, 14'h000);
        #3;
        chk_bubble("reset");
        chk("reset.in_ready", {31'd0, in_ready}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("release.in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("first_edge.in_ready", {31'd0, in_ready}, 32'd1);

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            @(negedge clk);
            drive(v.iv, v.ordy, v.fl, v.pc);
            #1;
            chk($sformatf("v%0d.in_ready", i), {31'd0, in_ready},
                {31'd0, v.e_rdy});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.out_valid", i), {31'd0, out_valid},
                {31'd0, v.e_ov});
            chk($sformatf("v%0d.pc", i), {18'd0, pc_out},
                v.e_ov ? {18'd0, v.e_pc} : 32'd0);
            chk($sformatf("v%0d.instr", i), instruction_out,
                v.e_ov ? f_instr(v.e_pc) : 32'h00000013);
            chk($sformatf("v%0d.alu", i), alu_result_out,
                v.e_ov ? f_alu(v.e_pc) : 32'd0);
            chk($sformatf("v%0d.ctrl", i), {24'd0, ctrl_out},
                v.e_ov ? {24'd0, f_ctrl(v.e_pc)} : 32'd0);
        end

        // async reset between edges while holding entries
        @(negedge clk);
        drive(1, 0, 0, 14'h050);
        @(negedge clk);
        drive(1, 0, 0, 14'h054);
        @(negedge clk);
        drive(0, 1, 0, 14'h000);
        #1;
        chk("pre_rst.out_valid", {31'd0, out_valid}, 32'd1);
        chk("pre_rst.pc", {18'd0, pc_out}, 32'h50);
        #1;
        rst = 1'b0;
        #1;
        chk_bubble("async_rst");
        chk("async_rst.in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_rel.in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_rel.in_ready_after", {31'd0, in_ready}, 32'd1);
        chk_bubble("no_survivor");
        @(posedge clk);
        #1;
        chk("no_survivor2.out_valid", {31'd0, out_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
